// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported SRAM.
// A CPU port and a loader port share the memory. Each grant makes one
// IDLE -> ACCESS -> RESP pass. Any ACCESS that waits too long for
// i_mem_ready is aborted and reported through o_err.
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [11:0] i_cpu_addr,
  input  logic [15:0] i_cpu_wdata,
  output logic        o_cpu_ack,
  output logic [15:0] o_cpu_rdata,
  input  logic        i_ld_req,
  input  logic        i_ld_we,
  input  logic [11:0] i_ld_addr,
  input  logic [15:0] i_ld_wdata,
  output logic        o_ld_ack,
  output logic [15:0] o_ld_rdata,
  output logic        o_err,
  output logic        o_mem_cs,
  output logic        o_mem_we,
  output logic [11:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  input  logic [15:0] i_mem_rdata,
  input  logic        i_mem_ready,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        win_q, win_d;        // 1 = loader owns the current transaction
  logic        last_q, last_d;      // 1 = loader was granted last
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] ld_rdata_q, ld_rdata_d;
  logic        pick_ld;

  // Round-robin choice: a lone requester wins; on a tie, the port not granted last wins.
  always_comb begin
    pick_ld = i_ld_req;
    if (i_cpu_req && i_ld_req) pick_ld = ~last_q;
  end

  // Next-state logic and transaction bookkeeping.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    case (state_q)
      IDLE: begin
        if (i_cpu_req || i_ld_req) begin
          win_d   = pick_ld;
          we_d    = pick_ld ? i_ld_we    : i_cpu_we;
          addr_d  = pick_ld ? i_ld_addr  : i_cpu_addr;
          wdata_d = pick_ld ? i_ld_wdata : i_cpu_wdata;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (i_mem_ready) begin
          if (!we_q) begin
            if (win_q) ld_rdata_d  = i_mem_rdata;
            else       cpu_rdata_d = i_mem_rdata;
          end
          state_d = RESP;
        end else if (cnt_q == CNT_MAX) begin
          // Give up: ack with error and leave read data untouched.
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        last_d  = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset leaves the CPU winning the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      win_q       <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  // Outputs decode straight from registered state, so reset drops them at once.
  assign o_busy      = (state_q != IDLE);
  assign o_mem_cs    = (state_q == ACCESS);
  assign o_mem_we    = (state_q == ACCESS) && we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_cpu_ack   = (state_q == RESP) && !win_q;
  assign o_ld_ack    = (state_q == RESP) &&  win_q;
  assign o_err       = (state_q == RESP) &&  err_q;
  assign o_cpu_rdata = cpu_rdata_q;
  assign o_ld_rdata  = ld_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations,
// then random traffic checked every cycle against a transaction model.
module tb_mem_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req [2];
  logic        we  [2];
  logic [11:0] addr[2];
  logic [15:0] wd  [2];
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  logic        o_cpu_ack, o_ld_ack, o_err, o_mem_cs, o_mem_we, o_busy;
  logic [15:0] o_cpu_rdata, o_ld_rdata, o_mem_wdata;
  logic [11:0] o_mem_addr;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_cpu_req(req[0]), .i_cpu_we(we[0]), .i_cpu_addr(addr[0]), .i_cpu_wdata(wd[0]),
    .o_cpu_ack(o_cpu_ack), .o_cpu_rdata(o_cpu_rdata),
    .i_ld_req(req[1]), .i_ld_we(we[1]), .i_ld_addr(addr[1]), .i_ld_wdata(wd[1]),
    .o_ld_ack(o_ld_ack), .o_ld_rdata(o_ld_rdata),
    .o_err(o_err), .o_mem_cs(o_mem_cs), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Transaction model: the one outstanding grant and its progress.
  logic        m_valid, m_resp, m_err, m_we, m_last;
  int          m_who, m_wait;
  logic [11:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rd[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_resp = 0; m_err = 0; m_we = 0; m_last = 1;
    m_who = 0; m_wait = 0; m_addr = '0; m_wdata = '0;
    m_rd[0] = '0; m_rd[1] = '0;
  endtask

  // One clock edge of the transaction model, using inputs seen at that edge.
  task automatic model_step();
    if (m_resp) begin
      m_last = (m_who == 1);
      m_valid = 0; m_resp = 0; m_err = 0;
    end else if (m_valid) begin
      if (mem_ready) begin
        if (!m_we) m_rd[m_who] = mem_rdata;
        m_resp = 1; m_err = 0;
      end else if (m_wait == TO - 1) begin
        m_resp = 1; m_err = 1;
      end else begin
        m_wait++;
      end
    end else if (req[0] || req[1]) begin
      if (req[0] && req[1]) m_who = m_last ? 0 : 1;
      else                  m_who = req[1] ? 1 : 0;
      m_we = we[m_who]; m_addr = addr[m_who]; m_wdata = wd[m_who];
      m_valid = 1; m_resp = 0; m_wait = 0; m_err = 0;
    end
  endtask

  task automatic check_all();
    logic cs;
    cs = m_valid && !m_resp;
    chk("busy", o_busy, m_valid);
    chk("mem_cs", o_mem_cs, cs);
    chk("mem_we", o_mem_we, cs && m_we);
    if (cs) begin
      chk("mem_addr", o_mem_addr, m_addr);
      chk("mem_wdata", o_mem_wdata, m_wdata);
    end
    chk("cpu_ack", o_cpu_ack, m_resp && m_who == 0);
    chk("ld_ack", o_ld_ack, m_resp && m_who == 1);
    chk("err", o_err, m_resp && m_err);
    chk("cpu_rdata", o_cpu_rdata, m_rd[0]);
    chk("ld_rdata", o_ld_rdata, m_rd[1]);
    chk("ack_overlap", o_cpu_ack & o_ld_ack, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
    check_all();
  endtask

  // Called at a negedge: assert reset, check outputs fall at once, release later.
  task automatic do_reset();
    reset_n = 0;
    model_reset();
    #1;
    chk("rst_cs", o_mem_cs, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_acks", {o_cpu_ack, o_ld_ack, o_err, o_mem_we}, 0);
    check_all();
    tick(); tick();
    reset_n = 1;
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [11:0] a, input logic [15:0] d);
    req[p] = r; we[p] = w; addr[p] = a; wd[p] = d;
  endtask

  initial begin
    for (int p = 0; p < 2; p++) set_port(p, 0, 0, '0, '0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_rdata", {o_cpu_rdata, o_ld_rdata}, 0);
    chk("rst_addr", {o_mem_addr, o_mem_wdata}, 0);
    reset_n = 1;

    // Both ports requesting continuously: CPU, loader, CPU with an idle gap.
    set_port(0, 1, 0, 12'h010, 16'h0);
    set_port(1, 1, 0, 12'h020, 16'h0);
    mem_ready = 1; mem_rdata = 16'h1111;
    for (int t = 1; t <= 8; t++) begin
      tick();
      chk("rr_cpu_ack", o_cpu_ack, (t == 2 || t == 8));
      chk("rr_ld_ack", o_ld_ack, (t == 5));
      if (t == 3 || t == 6) chk("rr_idle_gap", o_busy, 0);
      if (t == 4) chk("rr_ld_addr", o_mem_addr, 12'h020);
    end
    set_port(0, 0, 0, '0, '0); set_port(1, 0, 0, '0, '0);
    mem_ready = 0;
    tick();
    do_reset();

    // CPU read with immediate ready.
    set_port(0, 1, 0, 12'h123, 16'h0);
    tick();
    chk("rd_cs", o_mem_cs, 1);
    chk("rd_addr", o_mem_addr, 12'h123);
    chk("rd_ack_early", o_cpu_ack, 0);
    mem_ready = 1; mem_rdata = 16'hBEEF;
    tick();
    chk("rd_ack", o_cpu_ack, 1);
    chk("rd_data", o_cpu_rdata, 16'hBEEF);
    chk("rd_err", o_err, 0);
    set_port(0, 0, 0, '0, '0); mem_ready = 0;
    tick();
    chk("rd_ack_once", o_cpu_ack, 0);

    // CPU read that never sees ready: four ACCESS cycles then error ack.
    set_port(0, 1, 0, 12'h0AA, 16'h0);
    mem_rdata = 16'hDEAD;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("to_cs", o_mem_cs, 1);
    end
    tick();
    chk("to_ack", o_cpu_ack, 1);
    chk("to_err", o_err, 1);
    chk("to_cs_off", o_mem_cs, 0);
    chk("to_rdata_kept", o_cpu_rdata, 16'hBEEF);
    set_port(0, 0, 0, '0, '0);
    tick();

    // Reset mid-ACCESS while the loader (winner after CPU's grant) is served.
    set_port(0, 1, 0, 12'h321, 16'h0);
    set_port(1, 1, 0, 12'h456, 16'h0);
    tick();
    chk("mid_ld_won", o_mem_addr, 12'h456);
    do_reset();
    tick();
    chk("post_rst_cpu", o_mem_addr, 12'h321);
    chk("post_rst_noack", o_ld_ack | o_cpu_ack, 0);
    mem_ready = 1; mem_rdata = 16'h7777;
    tick();
    chk("post_rst_ack", {o_cpu_ack, o_ld_ack}, 2'b10);
    set_port(0, 0, 0, '0, '0); set_port(1, 0, 0, '0, '0);
    mem_ready = 0;
    tick();

    // Loader write, ready after three wait cycles.
    set_port(1, 1, 1, 12'hFFF, 16'h5A5A);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("wr_cs", o_mem_cs, 1);
      chk("wr_we", o_mem_we, 1);
      chk("wr_addr", o_mem_addr, 12'hFFF);
      chk("wr_wdata", o_mem_wdata, 16'h5A5A);
      if (k == 4) begin mem_ready = 1; mem_rdata = 16'hAAAA; end
    end
    tick();
    chk("wr_ack", o_ld_ack, 1);
    chk("wr_err", o_err, 0);
    chk("wr_rdata_kept", o_ld_rdata, 16'h0000);
    set_port(1, 0, 0, '0, '0); mem_ready = 0;
    tick();
    chk("wr_ack_once", o_ld_ack, 0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req[p]) begin
          if ($urandom_range(0, 9) < 3)
            set_port(p, 1, 1'($urandom), 12'($urandom), 16'($urandom));
        end else if (m_resp && m_who == p) begin
          if ($urandom_range(0, 1) == 0) req[p] = 0;
        end else if (m_valid && !m_resp && m_who == p) begin
          if ($urandom_range(0, 9) == 0) req[p] = 0;
        end
      end
      mem_ready = ($urandom_range(0, 9) < 5);
      mem_rdata = 16'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
